// File: rtl/fill_rect_gen_engine.sv
// Fill-rect pixel generator: clips one rectangle command to the screen and streams
// one frame-buffer write per pixel in raster order to the memory arbiter.
//
//  state | meaning
//  IDLE  | ready for a command (cmd_rtr high), latch fields on accept
//  CALC  | clip to screen, detect null rectangle, set up first address
//  GEN   | present one pixel write per cycle, advance on arbiter accept
//  DONE  | one-cycle completion pulse, then back to IDLE
module fill_rect_gen_engine #(
    parameter int SCR_W  = 640,
    parameter int SCR_H  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_rts,
    output logic              o_cmd_rtr,
    input  logic [15:0]       i_cmd_data_origx,
    input  logic [15:0]       i_cmd_data_origy,
    input  logic [15:0]       i_cmd_data_wid,
    input  logic [15:0]       i_cmd_data_hgt,
    input  logic [3:0]        i_cmd_data_rval,
    input  logic [3:0]        i_cmd_data_gval,
    input  logic [3:0]        i_cmd_data_bval,
    output logic [3:0]        o_fill_rect_gen_eng_state,
    output logic              o_arb_rts,
    input  logic              i_arb_rtr,
    output logic [ADDR_W-1:0] o_arb_addr,
    output logic [11:0]       o_arb_data,
    output logic              o_fill_rect_done
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_CALC = 4'd1,
        S_GEN  = 4'd2,
        S_DONE = 4'd3
    } state_t;

    localparam logic [16:0]       SCR_W17 = 17'(SCR_W);
    localparam logic [16:0]       SCR_H17 = 17'(SCR_H);
    localparam logic [ADDR_W-1:0] SCR_W_A = ADDR_W'(SCR_W);

    state_t              r_state;
    logic [15:0]         r_origx, r_origy, r_wid, r_hgt;
    logic [15:0]         r_x, r_y;
    logic [16:0]         r_x_end, r_y_end;
    logic [ADDR_W-1:0]   r_row_base;
    logic [ADDR_W-1:0]   r_arb_addr;
    logic [11:0]         r_arb_data;
    logic                r_arb_rts;
    logic                r_done;

    logic                w_cmd_xfc, w_arb_xfc, w_null;
    logic [16:0]         w_x_sum, w_y_sum, w_x_end, w_y_end, w_x_nxt, w_y_nxt;
    logic [ADDR_W-1:0]   w_row_base0;

    assign w_cmd_xfc = i_cmd_rts & o_cmd_rtr;
    assign w_arb_xfc = r_arb_rts & i_arb_rtr;

    // 17-bit sums so a huge origin+size never wraps back onto the screen
    assign w_x_sum = {1'b0, r_origx} + {1'b0, r_wid};
    assign w_y_sum = {1'b0, r_origy} + {1'b0, r_hgt};
    assign w_x_end = (w_x_sum > SCR_W17) ? SCR_W17 : w_x_sum;
    assign w_y_end = (w_y_sum > SCR_H17) ? SCR_H17 : w_y_sum;
    assign w_null  = (r_wid == 16'd0) | (r_hgt == 16'd0) |
                     ({1'b0, r_origx} >= SCR_W17) | ({1'b0, r_origy} >= SCR_H17);

    assign w_row_base0 = ADDR_W'(r_origy) * SCR_W_A;
    assign w_x_nxt     = {1'b0, r_x} + 17'd1;
    assign w_y_nxt     = {1'b0, r_y} + 17'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_origx    <= '0;
            r_origy    <= '0;
            r_wid      <= '0;
            r_hgt      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_x_end    <= '0;
            r_y_end    <= '0;
            r_row_base <= '0;
            r_arb_addr <= '0;
            r_arb_data <= '0;
            r_arb_rts  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_xfc) begin
                        r_origx    <= i_cmd_data_origx;
                        r_origy    <= i_cmd_data_origy;
                        r_wid      <= i_cmd_data_wid;
                        r_hgt      <= i_cmd_data_hgt;
                        r_arb_data <= {i_cmd_data_rval, i_cmd_data_gval, i_cmd_data_bval};
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_x_end <= w_x_end;
                    r_y_end <= w_y_end;
                    if (w_null) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_row_base <= w_row_base0;
                        r_x        <= r_origx;
                        r_y        <= r_origy;
                        r_arb_addr <= w_row_base0 + ADDR_W'(r_origx);
                        r_arb_rts  <= 1'b1;
                        r_state    <= S_GEN;
                    end
                end
                S_GEN: begin
                    if (w_arb_xfc) begin
                        if (w_x_nxt < r_x_end) begin
                            r_x        <= r_x + 16'd1;
                            r_arb_addr <= r_arb_addr + 1'b1;
                        end else if (w_y_nxt < r_y_end) begin
                            r_y        <= r_y + 16'd1;
                            r_x        <= r_origx;
                            r_row_base <= r_row_base + SCR_W_A;
                            r_arb_addr <= r_row_base + SCR_W_A + ADDR_W'(r_origx);
                        end else begin
                            r_arb_rts <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_rtr                 = (r_state == S_IDLE) & ~i_rst;
    assign o_fill_rect_gen_eng_state = r_state;
    assign o_arb_rts                 = r_arb_rts;
    assign o_arb_addr                = r_arb_addr;
    assign o_arb_data                = r_arb_data;
    assign o_fill_rect_done          = r_done;

endmodule

// File: tb/tb_fill_rect_gen_engine.sv
// Bench for fill_rect_gen_engine: directed and random rectangles scored against a
// queue of expected pixel addresses built from the clipping rules.
module tb_fill_rect_gen_engine;

    localparam int SCR_W  = 640;
    localparam int SCR_H  = 480;
    localparam int ADDR_W = 19;

    typedef struct packed {
        logic [15:0] ox, oy, w, h;
        logic [3:0]  r, g, b;
    } cmd_t;

    logic              clk = 1'b0;
    logic              i_rst, i_cmd_rts, i_arb_rtr;
    logic [15:0]       i_origx, i_origy, i_wid, i_hgt;
    logic [3:0]        i_rval, i_gval, i_bval;
    logic              o_cmd_rtr, o_arb_rts, o_done;
    logic [3:0]        o_state;
    logic [ADDR_W-1:0] o_arb_addr;
    logic [11:0]       o_arb_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fill_rect_gen_engine #(.SCR_W(SCR_W), .SCR_H(SCR_H), .ADDR_W(ADDR_W)) dut (
        .i_clk                     (clk),
        .i_rst                     (i_rst),
        .i_cmd_rts                 (i_cmd_rts),
        .o_cmd_rtr                 (o_cmd_rtr),
        .i_cmd_data_origx          (i_origx),
        .i_cmd_data_origy          (i_origy),
        .i_cmd_data_wid            (i_wid),
        .i_cmd_data_hgt            (i_hgt),
        .i_cmd_data_rval           (i_rval),
        .i_cmd_data_gval           (i_gval),
        .i_cmd_data_bval           (i_bval),
        .o_fill_rect_gen_eng_state (o_state),
        .o_arb_rts                 (o_arb_rts),
        .i_arb_rtr                 (i_arb_rtr),
        .o_arb_addr                (o_arb_addr),
        .o_arb_data                (o_arb_data),
        .o_fill_rect_done          (o_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input int ox, oy, w, h, input int r, g, b);
        cmd_t c;
        c.ox = 16'(ox); c.oy = 16'(oy); c.w = 16'(w); c.h = 16'(h);
        c.r = 4'(r); c.g = 4'(g); c.b = 4'(b);
        return c;
    endfunction

    task automatic drive_cmd(input cmd_t c);
        i_cmd_rts = 1'b1;
        i_origx = c.ox; i_origy = c.oy; i_wid = c.w; i_hgt = c.h;
        i_rval = c.r; i_gval = c.g; i_bval = c.b;
    endtask

    // Raster list of the clipped rectangle, straight from the screen geometry.
    task automatic build_expected(input cmd_t c, output int q[$]);
        int xe, ye;
        q = {};
        xe = (int'(c.ox) + int'(c.w) > SCR_W) ? SCR_W : int'(c.ox) + int'(c.w);
        ye = (int'(c.oy) + int'(c.h) > SCR_H) ? SCR_H : int'(c.oy) + int'(c.h);
        for (int y = int'(c.oy); y < ye; y++)
            for (int x = int'(c.ox); x < xe; x++)
                q.push_back(y * SCR_W + x);
    endtask

    // Called at a negedge with the engine idle. mode: 0 rtr=1, 1 random, 2 pattern 1-0-0-1.
    task automatic do_cmd(input cmd_t c, input int mode, input bit hold, input cmd_t nxt);
        int     exp_a[$];
        int     n, budget, last_xfc;
        bit     finished, prev_done, exp_done;
        logic [11:0] exp_d;
        build_expected(c, exp_a);
        n        = exp_a.size();
        exp_d    = {c.r, c.g, c.b};
        budget   = 4 * n + 20;
        last_xfc = -10;
        finished = 0;
        prev_done = 0;
        chk("idle_rtr", o_cmd_rtr, 1);
        chk("idle_state", o_state, 0);
        drive_cmd(c);
        @(posedge clk); #1;
        if (hold) drive_cmd(nxt);
        else begin
            i_cmd_rts = 1'b0;
            i_origx = 16'($urandom); i_origy = 16'($urandom);
            i_wid = 16'($urandom); i_hgt = 16'($urandom);
            i_rval = 4'($urandom); i_gval = 4'($urandom); i_bval = 4'($urandom);
        end
        @(negedge clk);
        chk("calc_state", o_state, 1);
        chk("calc_rts", o_arb_rts, 0);
        chk("calc_rtr", o_cmd_rtr, 0);
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk); #1;
            case (mode)
                0:       i_arb_rtr = 1'b1;
                1:       i_arb_rtr = 1'($urandom_range(0, 1));
                default: i_arb_rtr = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
            endcase
            @(negedge clk);
            if (prev_done) begin
                chk("post_state", o_state, 0);
                chk("post_rtr", o_cmd_rtr, 1);
                chk("post_done", o_done, 0);
                chk("post_rts", o_arb_rts, 0);
                finished = 1;
                break;
            end
            exp_done = (n == 0) ? (cyc == 1) : (exp_a.size() == 0 && cyc == last_xfc + 1);
            chk("arb_rts", o_arb_rts, exp_a.size() != 0);
            chk("done", o_done, exp_done);
            chk("state", o_state, (exp_a.size() != 0) ? 2 : (exp_done ? 3 : 0));
            chk("busy_rtr", o_cmd_rtr, 0);
            if (o_arb_rts && exp_a.size() != 0) begin
                chk("arb_addr", o_arb_addr, exp_a[0]);
                chk("arb_data", o_arb_data, exp_d);
                if (i_arb_rtr) begin
                    void'(exp_a.pop_front());
                    last_xfc = cyc;
                end
            end
            prev_done = exp_done;
        end
        chk("finished", finished, 1);
        chk("pixels_left", exp_a.size(), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c, dummy;
        int   ox, oy, w, h;
        dummy = '0;
        i_rst = 1'b1; i_cmd_rts = 1'b0; i_arb_rtr = 1'b0;
        i_origx = '0; i_origy = '0; i_wid = '0; i_hgt = '0;
        i_rval = '0; i_gval = '0; i_bval = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rtr", o_cmd_rtr, 0);
        chk("rst_state", o_state, 0);
        chk("rst_rts", o_arb_rts, 0);
        chk("rst_addr", o_arb_addr, 0);
        chk("rst_data", o_arb_data, 0);
        chk("rst_done", o_done, 0);
        i_rst = 1'b0;
        @(negedge clk);
        chk("rel_rtr", o_cmd_rtr, 1);

        c = mk(1, 1, 2, 2, 15, 0, 10);
        do_cmd(c, 0, 0, dummy);
        do_cmd(c, 2, 0, dummy);
        do_cmd(mk(638, 479, 4, 3, 1, 2, 3), 0, 0, dummy);
        do_cmd(mk(5, 5, 0, 3, 7, 7, 7), 0, 0, dummy);
        do_cmd(mk(640, 0, 3, 3, 4, 5, 6), 1, 0, dummy);
        do_cmd(mk(0, 0, 3, 0, 4, 5, 6), 0, 0, dummy);
        do_cmd(mk(100, 200, 3, 2, 9, 8, 7), 1, 1, mk(300, 10, 2, 3, 3, 6, 9));
        do_cmd(mk(300, 10, 2, 3, 3, 6, 9), 0, 0, dummy);
        do_cmd(mk(630, 470, 65535, 65535, 12, 1, 5), 1, 0, dummy);

        // synchronous reset in the middle of a 4x4 fill
        c = mk(10, 20, 4, 4, 2, 4, 8);
        drive_cmd(c);
        @(posedge clk); #1;
        i_cmd_rts = 1'b0;
        i_arb_rtr = 1'b1;
        @(negedge clk);
        chk("rstmid_calc", o_state, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            if (k == 2) begin #1; i_rst = 1'b1; end
            @(negedge clk);
            chk("rstmid_rts", o_arb_rts, 1);
            chk("rstmid_addr", o_arb_addr, 20 * SCR_W + 10 + k);
        end
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_rts_low", o_arb_rts, 0);
        chk("rstmid_state", o_state, 0);
        chk("rstmid_done", o_done, 0);
        chk("rstmid_rtr", o_cmd_rtr, 0);
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rstpost_done", o_done, 0);
            chk("rstpost_state", o_state, 0);
            chk("rstpost_rtr", o_cmd_rtr, 1);
            chk("rstpost_rts", o_arb_rts, 0);
        end
        do_cmd(c, 0, 0, dummy);

        for (int t = 0; t < 25; t++) begin
            ox = ($urandom_range(0, 1) == 1) ? int'($urandom_range(600, 660)) : int'($urandom_range(0, 700));
            oy = ($urandom_range(0, 1) == 1) ? int'($urandom_range(470, 490)) : int'($urandom_range(0, 500));
            w  = (ox >= 600 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 8));
            h  = (oy >= 470 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) ox = int'($urandom_range(60000, 65535));
            do_cmd(mk(ox, oy, w, h, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15))), int'($urandom_range(0, 2)), 0, dummy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
